// File: rtl/rop3_mode_extract_if.sv
// Operand/result sample bus for the ROP3 mode extractor, with the recovered-mode outputs.
interface rop3_mode_extract_if #(parameter int unsigned N = 4);
   logic         start;
   logic         in_valid;
   logic [N-1:0] P;
   logic [N-1:0] S;
   logic [N-1:0] D;
   logic [N-1:0] Result;
   logic [7:0]   Mode;
   logic         mode_valid;
   logic         mode_supported;
   logic         conflict;
   logic [7:0]   known_mask;

   modport master (
      output start, in_valid, P, S, D, Result,
      input  Mode, mode_valid, mode_supported, conflict, known_mask
   );

   modport slave (
      input  start, in_valid, P, S, D, Result,
      output Mode, mode_valid, mode_supported, conflict, known_mask
   );
endinterface

// File: rtl/rop3_mode_extract.sv
// Recovers an 8-bit ROP3 code from observed {P,S,D} -> Result samples.
// Define ROP3_SUPPORT_CHECK_EN to flag recovered codes outside the supported set.
module rop3_mode_extract #(
   parameter int unsigned N = 4
) (
   input logic               clk,
   input logic               rst_n,
   rop3_mode_extract_if.slave bus
);

   typedef enum logic [1:0] {IDLE, COLLECT, DONE, ERROR} state_e;

   state_e       state_q, state_d;
   logic         start_q, start_d;
   logic         valid_q, valid_d;
   logic [N-1:0] p_q, p_d, s_q, s_d, d_q, d_d, r_q, r_d;
   logic [7:0]   table_q, table_d;
   logic [7:0]   known_q, known_d;
   logic [7:0]   mode_q, mode_d;
   logic         mode_valid_q, mode_valid_d;
   logic         supported_q, supported_d;
   logic         conflict_q, conflict_d;

   logic [2:0]   m;
   logic [7:0]   beat_seen, beat_val, merged_known, merged_table;
   logic         beat_conflict;

`ifdef ROP3_SUPPORT_CHECK_EN
   function automatic logic is_supported(input logic [7:0] code);
      case (code)
         8'h00, 8'h11, 8'h33, 8'h44, 8'h55, 8'h5A, 8'h66, 8'h88,
         8'hBB, 8'hC0, 8'hCC, 8'hEE, 8'hF0, 8'hFB, 8'hFF: return 1'b1;
         default:                                        return 1'b0;
      endcase
   endfunction
`endif

   // Input stage: every beat is registered before it is interpreted.
   always_comb begin
      start_d = bus.start;
      valid_d = bus.in_valid;
      p_d     = bus.P;
      s_d     = bus.S;
      d_d     = bus.D;
      r_d     = bus.Result;
   end

   always_comb begin
      state_d       = state_q;
      table_d       = table_q;
      known_d       = known_q;
      mode_d        = mode_q;
      mode_valid_d  = mode_valid_q;
      supported_d   = supported_q;
      conflict_d    = conflict_q;
      m             = 3'd0;
      beat_seen     = 8'h00;
      beat_val      = 8'h00;
      beat_conflict = 1'b0;

      // A beat contradicts either the learned table or one of its own earlier bits.
      for (int i = 0; i < int'(N); i++) begin
         m = {p_q[i], s_q[i], d_q[i]};
         if (known_q[m] && (table_q[m] != r_q[i]))
            beat_conflict = 1'b1;
         if (beat_seen[m] && (beat_val[m] != r_q[i]))
            beat_conflict = 1'b1;
         beat_seen[m] = 1'b1;
         beat_val[m]  = r_q[i];
      end

      merged_known = known_q | beat_seen;
      merged_table = table_q | (beat_val & ~known_q);

      if (start_q) begin
         state_d      = COLLECT;
         table_d      = 8'h00;
         known_d      = 8'h00;
         mode_d       = 8'h00;
         mode_valid_d = 1'b0;
         supported_d  = 1'b0;
         conflict_d   = 1'b0;
      end else if (valid_q && (state_q == COLLECT)) begin
         if (beat_conflict) begin
            state_d    = ERROR;
            conflict_d = 1'b1;
         end else begin
            known_d = merged_known;
            table_d = merged_table;
            if (&merged_known) begin
               state_d      = DONE;
               mode_d       = merged_table;
               mode_valid_d = 1'b1;
`ifdef ROP3_SUPPORT_CHECK_EN
               supported_d  = is_supported(merged_table);
`else
               supported_d  = 1'b1;
`endif
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         start_q      <= 1'b0;
         valid_q      <= 1'b0;
         p_q          <= '0;
         s_q          <= '0;
         d_q          <= '0;
         r_q          <= '0;
         table_q      <= 8'h00;
         known_q      <= 8'h00;
         mode_q       <= 8'h00;
         mode_valid_q <= 1'b0;
         supported_q  <= 1'b0;
         conflict_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_q      <= start_d;
         valid_q      <= valid_d;
         p_q          <= p_d;
         s_q          <= s_d;
         d_q          <= d_d;
         r_q          <= r_d;
         table_q      <= table_d;
         known_q      <= known_d;
         mode_q       <= mode_d;
         mode_valid_q <= mode_valid_d;
         supported_q  <= supported_d;
         conflict_q   <= conflict_d;
      end
   end

   assign bus.Mode           = mode_q;
   assign bus.mode_valid     = mode_valid_q;
   assign bus.mode_supported = supported_q;
   assign bus.conflict       = conflict_q;
   assign bus.known_mask     = known_q;

endmodule

// File: tb/tb_rop3_mode_extract.sv
// Directed plus randomized bench for rop3_mode_extract against a truth-table reference model.
module tb_rop3_mode_extract;
   localparam int unsigned N = 4;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   rop3_mode_extract_if #(.N(N)) bus ();

   rop3_mode_extract #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: 0 idle, 1 collecting, 2 done, 3 error.
   int       m_state;
   bit [7:0] m_known;
   bit [7:0] m_table;
   bit [7:0] target;

   bit [7:0] supported_list [15] = '{8'h00, 8'h11, 8'h33, 8'h44, 8'h55, 8'h5A, 8'h66, 8'h88,
                                     8'hBB, 8'hC0, 8'hCC, 8'hEE, 8'hF0, 8'hFB, 8'hFF};

   task automatic mdl_reset();
      m_state = 0;
      m_known = 8'h00;
      m_table = 8'h00;
   endtask

   task automatic mdl_start();
      m_state = 1;
      m_known = 8'h00;
      m_table = 8'h00;
   endtask

   task automatic mdl_beat(input bit [3:0] p, input bit [3:0] s, input bit [3:0] d, input bit [3:0] r);
      int  seen [8];
      int  idx;
      bit  bad;
      if (m_state != 1) return;
      bad = 1'b0;
      for (int k = 0; k < 8; k++) seen[k] = -1;
      for (int i = 0; i < 4; i++) begin
         idx = 4 * int'(p[i]) + 2 * int'(s[i]) + int'(d[i]);
         if (seen[idx] != -1 && seen[idx] != int'(r[i])) bad = 1'b1;
         if (m_known[idx] && int'(m_table[idx]) != int'(r[i])) bad = 1'b1;
         seen[idx] = int'(r[i]);
      end
      if (bad) begin
         m_state = 3;
         return;
      end
      for (int k = 0; k < 8; k++)
         if (seen[k] != -1 && !m_known[k]) begin
            m_known[k] = 1'b1;
            m_table[k] = seen[k][0];
         end
      if (m_known == 8'hFF) m_state = 2;
   endtask

   function automatic bit exp_supported();
      bit hit = 1'b0;
      if (m_state != 2) return 1'b0;
`ifdef ROP3_SUPPORT_CHECK_EN
      foreach (supported_list[k]) if (supported_list[k] == m_table) hit = 1'b1;
`else
      hit = 1'b1;
`endif
      return hit;
   endfunction

   task automatic check_outputs(input string tag);
      bit [7:0] e_mode;
      e_mode = (m_state == 2) ? m_table : 8'h00;
      checks++;
      assert (bus.known_mask === m_known) else begin
         failures++;
         $error("FAIL %s known_mask got=%h exp=%h", tag, bus.known_mask, m_known);
      end
      checks++;
      assert (bus.Mode === e_mode) else begin
         failures++;
         $error("FAIL %s Mode got=%h exp=%h", tag, bus.Mode, e_mode);
      end
      checks++;
      assert (bus.mode_valid === (m_state == 2)) else begin
         failures++;
         $error("FAIL %s mode_valid got=%b exp=%b", tag, bus.mode_valid, (m_state == 2));
      end
      checks++;
      assert (bus.conflict === (m_state == 3)) else begin
         failures++;
         $error("FAIL %s conflict got=%b exp=%b", tag, bus.conflict, (m_state == 3));
      end
      checks++;
      assert (bus.mode_supported === exp_supported()) else begin
         failures++;
         $error("FAIL %s mode_supported got=%b exp=%b", tag, bus.mode_supported, exp_supported());
      end
   endtask

   // One presented beat: outputs must be unchanged one cycle later and updated two cycles later.
   task automatic op(input string tag, input bit st, input bit v,
                     input bit [3:0] p, input bit [3:0] s, input bit [3:0] d, input bit [3:0] r);
      @(negedge clk);
      bus.start = st; bus.in_valid = v;
      bus.P = p; bus.S = s; bus.D = d; bus.Result = r;
      @(negedge clk);
      bus.start = 1'b0; bus.in_valid = 1'b0;
      check_outputs({tag, "_c1"});
      if (st) mdl_start();
      else if (v) mdl_beat(p, s, d, r);
      @(negedge clk);
      check_outputs({tag, "_c2"});
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      mdl_reset();
      check_outputs(tag);
   endtask

   function automatic bit [3:0] mode_result(input bit [7:0] md, input bit [3:0] p,
                                            input bit [3:0] s, input bit [3:0] d);
      bit [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = md[4 * int'(p[i]) + 2 * int'(s[i]) + int'(d[i])];
      return r;
   endfunction

   initial begin
      bit [3:0] p, s, d, r;
      int       sel;
      checks = 0; failures = 0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.in_valid = 1'b0;
      bus.P = '0; bus.S = '0; bus.D = '0; bus.Result = '0;
      mdl_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check_outputs("reset");

      op("idle_beat", 1'b0, 1'b1, 4'b0000, 4'b1100, 4'b1010, 4'b1010);
      op("x5a_start", 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      op("x5a_b1", 1'b0, 1'b1, 4'b0000, 4'b1100, 4'b1010, 4'b1010);
      op("x5a_b2", 1'b0, 1'b1, 4'b1111, 4'b1100, 4'b1010, 4'b0101);
      op("done_ignore", 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b1111);

      op("cf_start", 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      op("cf_b1", 1'b0, 1'b1, 4'b0000, 4'b1100, 4'b1010, 4'b1010);
      op("cf_b2", 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
      op("err_hold", 1'b0, 1'b1, 4'b1111, 4'b1100, 4'b1010, 4'b0101);

      op("intra_start", 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      op("intra_b", 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0011);

      op("x96_start", 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      op("x96_b1", 1'b0, 1'b1, 4'b0000, 4'b1100, 4'b1010, 4'b0110);
      op("x96_b2", 1'b0, 1'b1, 4'b1111, 4'b1100, 4'b1010, 4'b1001);

      op("rst_start", 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      op("rst_b1", 1'b0, 1'b1, 4'b0000, 4'b1100, 4'b1010, 4'b1010);
      do_reset("mid_reset");
      op("rst_start2", 1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0);
      op("rst_b2", 1'b0, 1'b1, 4'b1111, 4'b1100, 4'b1010, 4'b0101);
      op("start_beat", 1'b1, 1'b1, 4'b0000, 4'b1100, 4'b1010, 4'b1010);

      target = supported_list[$urandom_range(0, 14)];
      for (int it = 0; it < 80; it++) begin
         sel = int'($urandom_range(0, 11));
         p = 4'($urandom); s = 4'($urandom); d = 4'($urandom);
         r = ($urandom_range(0, 4) == 0) ? 4'($urandom) : mode_result(target, p, s, d);
         if (sel == 0) begin
            target = ($urandom_range(0, 1) == 0) ? supported_list[$urandom_range(0, 14)] : 8'($urandom);
            op("rnd_start", 1'b1, 1'b0, p, s, d, r);
         end else if (sel == 1) begin
            do_reset("rnd_reset");
         end else if (sel == 2) begin
            op("rnd_start_beat", 1'b1, 1'b1, p, s, d, r);
         end else begin
            op("rnd_beat", 1'b0, 1'b1, p, s, d, r);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
